button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
// - Conditions the two raw active-low board buttons into clean active-high SET/RESET levels.
// - Sits directly upstream of the SR flip-flop stage and drives its SET and RESET inputs.
// - Per button: 2-flop synchronizer, tick-based stability counter and 4-state FSM.
// - Uses its own prescaler on the 100 MHz CLK.
// PARAMETERS
// - CNT_W         12  prescaler width; one tick every 2**CNT_W CLK cycles (4096 -> ~24.4 kHz)
// - STABLE_TICKS  8   consecutive ticks an input must hold before the output changes (1..255)
// - SYNC_STAGES   2   synchronizer depth (>=2)
// PORTS
// - CLK          in   1  system clock (100 MHz)
// - RST          in   1  asynchronous, active-high reset
// - BUT1         in   1  raw button 1, active-low, asynchronous
// - BUT2         in   1  raw button 2, active-low, asynchronous
// - SET          out  1  debounced BUT1, active-high level
// - RESET        out  1  debounced BUT2, active-high level
// - SET_PULSE    out  1  1-CLK pulse on debounced BUT1 press (see CONFIGURATION)
// - RESET_PULSE  out  1  1-CLK pulse on debounced BUT2 press (see CONFIGURATION)
// BEHAVIOUR
// - Clock and reset: one clock (CLK); reset (RST) is asynchronous and active-high.
// - On RST:
//   - prescaler = 0 and stability counters = 0
//   - sync flops = 1 (released)
//   - both FSMs in REL
//   - SET = RESET = SET_PULSE = RESET_PULSE = 0
// - Prescaler: free-running CNT_W-bit up-counter that wraps.
//   - tick = 1 for exactly one CLK cycle when the count is all-ones.
// - Sampled input: p = ~sync_out (1 = pressed), taken after SYNC_STAGES flops.
// - Per-channel FSM. All outputs are registered; the output changes on the cycle after a state change.
//   - REL (out 0):
//     - if p = 1, go to PWAIT and set cnt = 0.
//   - PWAIT (out 0):
//     - if p = 0 on any cycle, go to REL and set cnt = 0.
//     - else, on each tick, cnt += 1.
//     - on the tick where cnt reaches STABLE_TICKS, go to PRS and fire the press pulse.
//   - PRS (out 1):
//     - if p = 0, go to RWAIT and set cnt = 0.
//   - RWAIT (out 1):
//     - if p = 1 on any cycle, go to PRS and set cnt = 0; no pulse.
//     - else count ticks as in PWAIT; at STABLE_TICKS go to REL.
// - A glitch shorter than one full tick interval never changes the output.
// - Press latency after the raw edge:
//   - SYNC_STAGES + 1 cycles to enter the wait state,
//   - then the STABLE_TICKS-th tick,
//   - then 1 cycle for the output register.
// - Both channels are fully independent.
//   - Simultaneous presses assert SET and RESET together; no arbitration here.
//   - The downstream SR stage owns conflict handling.
// - cnt width is 8 bits and saturates, so it never wraps.
// - Prescaler wrap has no side effect on the FSMs.
// - RST asserted mid-debounce: everything returns to reset values immediately.
//   - The button must then be re-qualified from REL.
// CONFIGURATION
// - DEBOUNCE_PULSE_EN defined:
//   - SET_PULSE/RESET_PULSE are registered, high for exactly 1 CLK on the PWAIT->PRS transition.
//   - They coincide with the rising edge of SET/RESET.
// - DEBOUNCE_PULSE_EN undefined:
//   - SET_PULSE/RESET_PULSE are tied to constant 0.
//   - No pulse registers are synthesized; the ports remain.
// TESTING (CNT_W=4 -> tick every 16 cycles, STABLE_TICKS=3, SYNC_STAGES=2, DEBOUNCE_PULSE_EN defined)
// - Reset: assert RST mid-count with BUT1=0 -> all outputs 0 at once; after release, SET=0 until 3 new ticks.
// - Clean press: BUT1 1->0 and held -> SET=1 and SET_PULSE=1 for 1 cycle, after the 3rd tick plus 1 cycle.
//   - Measured latency must be 35..51 cycles.
// - Bounce: BUT1 toggles every 5 cycles for 60 cycles, then holds 0 -> no SET activity during toggling.
//   - SET rises after 3 clean ticks; exactly one SET_PULSE.
// - Release: held BUT1 goes 0->1 -> SET falls after 3 ticks; no pulse on release.
//   - A 4-cycle 0-glitch during RWAIT keeps SET=1.
// - Both buttons: BUT1 and BUT2 pressed in the same cycle -> SET and RESET rise in the same cycle.
//   - SET_PULSE and RESET_PULSE also fire in that same cycle.
// - Macro off: rerun the clean-press test -> SET/RESET timing identical; SET_PULSE/RESET_PULSE stay 0 throughout.

Source files
------------

// File: rtl/button_debounce.sv
// Debounces two raw active-low buttons into clean active-high SET/RESET levels.
// Optional DEBOUNCE_PULSE_EN adds registered 1-CLK press pulses.
module button_debounce #(
  parameter int CNT_W        = 12,
  parameter int STABLE_TICKS = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUT1,
  input  logic BUT2,
  output logic SET,
  output logic RESET,
  output logic SET_PULSE,
  output logic RESET_PULSE
);

  typedef enum logic [1:0] {REL, PWAIT, PRS, RWAIT} state_t;

  localparam logic [7:0] STABLE_N = 8'(STABLE_TICKS);

  logic [CNT_W-1:0]       presc;
  logic                   tick;
  logic [1:0]             raw;
  logic [1:0]             p;
  logic [SYNC_STAGES-1:0] sync_q  [2];
  state_t                 state_q [2];
  state_t                 state_d [2];
  logic [7:0]             cnt_q   [2];
  logic [7:0]             cnt_d   [2];
  logic [7:0]             cnt_inc [2];
  logic [1:0]             lvl_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) presc <= '0;
    else     presc <= presc + 1'b1;
  end

  assign tick = &presc;
  assign raw  = {BUT2, BUT1};
  assign p    = {~sync_q[1][SYNC_STAGES-1], ~sync_q[0][SYNC_STAGES-1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= '1;  // released level, so reset never looks like a press
        state_q[i] <= REL;
        cnt_q[i]   <= '0;
      end
      lvl_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        lvl_q[i]   <= (state_d[i] == PRS) || (state_d[i] == RWAIT);
      end
    end
  end

  // NOTE: every signal written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_inc[i] = (cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1;
      case (state_q[i])
        REL: if (p[i]) begin
          state_d[i] = PWAIT;
          cnt_d[i]   = '0;
        end
        PWAIT: if (!p[i]) begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end else if (tick) begin
          if (cnt_inc[i] == STABLE_N) begin
            state_d[i] = PRS;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        PRS: if (!p[i]) begin
          state_d[i] = RWAIT;
          cnt_d[i]   = '0;
        end
        RWAIT: if (p[i]) begin
          state_d[i] = PRS;
          cnt_d[i]   = '0;
        end else if (tick) begin
          if (cnt_inc[i] == STABLE_N) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        default: begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign SET   = lvl_q[0];
  assign RESET = lvl_q[1];

`ifdef DEBOUNCE_PULSE_EN
  logic [1:0] fire;
  logic [1:0] pulse_q;

  // Only a qualified press fires; a bounce back from RWAIT to PRS does not.
  always_comb begin
    fire = '0;
    for (int i = 0; i < 2; i++)
      fire[i] = (state_q[i] == PWAIT) && (state_d[i] == PRS);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pulse_q <= '0;
    else     pulse_q <= fire;
  end

  assign SET_PULSE   = pulse_q[0];
  assign RESET_PULSE = pulse_q[1];
`else
  assign SET_PULSE   = 1'b0;
  assign RESET_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: randomized button activity compared
// cycle by cycle against a tick-counting reference model, plus scenario checks.
module tb_button_debounce;

  localparam int CNT_W        = 4;
  localparam int STABLE_TICKS = 3;
  localparam int SYNC_STAGES  = 2;
  localparam int PERIOD       = 1 << CNT_W;
  localparam int LAT_MIN      = 35;
  localparam int LAT_MAX      = 51;

`ifdef DEBOUNCE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, BUT1, BUT2;
  logic SET, RESET, SET_PULSE, RESET_PULSE;

  always #5 CLK = ~CLK;

  button_debounce #(
    .CNT_W(CNT_W), .STABLE_TICKS(STABLE_TICKS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK), .RST(RST), .BUT1(BUT1), .BUT2(BUT2),
    .SET(SET), .RESET(RESET), .SET_PULSE(SET_PULSE), .RESET_PULSE(RESET_PULSE)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulse_cnt [2];

  // Reference model: a channel's level flips once the sampled button has
  // disagreed with it continuously through STABLE_TICKS ticks, not counting a
  // tick that lands on the very first disagreeing cycle.
  int                     edges;
  bit                     m_lvl   [2];
  bit                     m_pulse [2];
  int                     m_run   [2];
  int                     m_tc    [2];
  logic [SYNC_STAGES-1:0] m_hist  [2];

  task automatic model_reset();
    edges = 0;
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 1'b0; m_pulse[c] = 1'b0; m_run[c] = 0; m_tc[c] = 0;
      m_hist[c] = '1;
    end
  endtask

  task automatic model_step();
    bit raw [2];
    bit tick;
    bit p;
    raw[0] = BUT1;
    raw[1] = BUT2;
    tick = (edges % PERIOD) == PERIOD - 1;
    for (int c = 0; c < 2; c++) begin
      p = ~m_hist[c][SYNC_STAGES-1];
      m_pulse[c] = 1'b0;
      if (p != m_lvl[c]) begin
        if (m_run[c] > 0 && tick) m_tc[c]++;
        m_run[c]++;
        if (m_tc[c] == STABLE_TICKS) begin
          m_lvl[c] = p; m_pulse[c] = p; m_run[c] = 0; m_tc[c] = 0;
        end
      end else begin
        m_run[c] = 0; m_tc[c] = 0;
      end
      m_hist[c] = {m_hist[c][SYNC_STAGES-2:0], raw[c]};
    end
    edges++;
  endtask

  // Advance one clock, update the model and compare all four outputs.
  task automatic cycle();
    logic [3:0] got, exp;
    @(posedge CLK);
    if (RST) model_reset();
    else     model_step();
    cyc++;
    #1;
    got = {SET, RESET, SET_PULSE, RESET_PULSE};
    exp = {m_lvl[0], m_lvl[1], PULSE_EN & m_pulse[0], PULSE_EN & m_pulse[1]};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL model_cycle %0d: {SET,RESET,SET_PULSE,RESET_PULSE} got %b expected %b",
                 cyc, got, exp);
    end
    pulse_cnt[0] += int'(SET_PULSE === 1'b1);
    pulse_cnt[1] += int'(RESET_PULSE === 1'b1);
  endtask

  task automatic test_reset();
    int lat;
    RST = 1'b1; BUT1 = 1'b1; BUT2 = 1'b1;
    model_reset();
    repeat (4) cycle();
    n_cmp++;
    if ({SET, RESET, SET_PULSE, RESET_PULSE} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_state: outputs %b expected 0000", {SET, RESET, SET_PULSE, RESET_PULSE});
    end
    @(negedge CLK); RST = 1'b0;
    BUT1 = 1'b0;
    lat = 0;
    while (SET !== 1'b1 && lat < 100) begin cycle(); lat++; end
    n_cmp++;
    if (SET !== 1'b1 || lat < LAT_MIN || lat > LAT_MAX) begin
      n_bad++; $display("FAIL reset_first_press: SET=%b latency %0d expected 1 within %0d..%0d", SET, lat, LAT_MIN, LAT_MAX);
    end
    repeat (5) cycle();
    #2; RST = 1'b1; model_reset(); #1;
    n_cmp++;
    if ({SET, RESET, SET_PULSE, RESET_PULSE} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_async_while_set: outputs %b expected 0000", {SET, RESET, SET_PULSE, RESET_PULSE});
    end
    repeat (2) cycle();
    @(negedge CLK); RST = 1'b0;
    repeat (20) cycle();
    #2; RST = 1'b1; model_reset(); #1;
    n_cmp++;
    if ({SET, RESET, SET_PULSE, RESET_PULSE} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_async_mid_count: outputs %b expected 0000", {SET, RESET, SET_PULSE, RESET_PULSE});
    end
    repeat (2) cycle();
    @(negedge CLK); RST = 1'b0;
    lat = 0;
    while (SET !== 1'b1 && lat < 100) begin cycle(); lat++; end
    n_cmp++;
    if (SET !== 1'b1 || lat < LAT_MIN || lat > LAT_MAX) begin
      n_bad++; $display("FAIL reset_requalify: SET=%b latency %0d expected 1 within %0d..%0d", SET, lat, LAT_MIN, LAT_MAX);
    end
    BUT1 = 1'b1;
    lat = 0;
    while (SET !== 1'b0 && lat < 100) begin cycle(); lat++; end
    repeat (3) cycle();
  endtask

  task automatic test_clean_press();
    int lat;
    logic sp;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 20)) cycle();
      pulse_cnt[0] = 0;
      BUT1 = 1'b0;
      lat = 0;
      while (SET !== 1'b1 && lat < 100) begin cycle(); lat++; end
      sp = SET_PULSE;
      n_cmp++;
      if (SET !== 1'b1 || lat < LAT_MIN || lat > LAT_MAX) begin
        n_bad++; $display("FAIL clean_press_latency: SET=%b latency %0d expected 1 within %0d..%0d", SET, lat, LAT_MIN, LAT_MAX);
      end
      n_cmp++;
      if (sp !== PULSE_EN) begin
        n_bad++; $display("FAIL clean_press_pulse_at_rise: SET_PULSE=%b expected %b", sp, PULSE_EN);
      end
      repeat (10) cycle();
      n_cmp++;
      if (pulse_cnt[0] != int'(PULSE_EN)) begin
        n_bad++; $display("FAIL clean_press_pulse_count: %0d pulses expected %0d", pulse_cnt[0], int'(PULSE_EN));
      end
      BUT1 = 1'b1;
      lat = 0;
      while (SET !== 1'b0 && lat < 100) begin cycle(); lat++; end
      n_cmp++;
      if (SET !== 1'b0) begin
        n_bad++; $display("FAIL clean_press_release: SET=%b after %0d cycles expected 0", SET, lat);
      end
    end
  endtask

  task automatic test_bounce();
    int lat;
    bit any_set;
    repeat ($urandom_range(1, 20)) cycle();
    pulse_cnt[0] = 0;
    any_set = 1'b0;
    for (int t = 0; t < 12; t++) begin
      BUT1 = t[0];
      repeat (5) begin cycle(); if (SET !== 1'b0) any_set = 1'b1; end
    end
    BUT1 = 1'b0;
    n_cmp++;
    if (any_set || pulse_cnt[0] != 0) begin
      n_bad++; $display("FAIL bounce_quiet: set_seen=%b pulses %0d expected 0/0", any_set, pulse_cnt[0]);
    end
    lat = 0;
    while (SET !== 1'b1 && lat < 100) begin cycle(); lat++; end
    n_cmp++;
    if (SET !== 1'b1 || lat < LAT_MIN || lat > LAT_MAX) begin
      n_bad++; $display("FAIL bounce_settle_latency: SET=%b latency %0d expected 1 within %0d..%0d", SET, lat, LAT_MIN, LAT_MAX);
    end
    repeat (10) cycle();
    n_cmp++;
    if (pulse_cnt[0] != int'(PULSE_EN)) begin
      n_bad++; $display("FAIL bounce_pulse_count: %0d pulses expected %0d", pulse_cnt[0], int'(PULSE_EN));
    end
    BUT1 = 1'b1;
    lat = 0;
    while (SET !== 1'b0 && lat < 100) begin cycle(); lat++; end
  endtask

  task automatic test_release();
    int lat;
    bit dropped;
    BUT1 = 1'b0;
    lat = 0;
    while (SET !== 1'b1 && lat < 100) begin cycle(); lat++; end
    repeat ($urandom_range(3, 20)) cycle();
    pulse_cnt[0] = 0;
    BUT1 = 1'b1;
    lat = 0;
    while (SET !== 1'b0 && lat < 100) begin cycle(); lat++; end
    n_cmp++;
    if (SET !== 1'b0 || lat < LAT_MIN || lat > LAT_MAX) begin
      n_bad++; $display("FAIL release_latency: SET=%b latency %0d expected 0 within %0d..%0d", SET, lat, LAT_MIN, LAT_MAX);
    end
    repeat (5) cycle();
    n_cmp++;
    if (pulse_cnt[0] != 0) begin
      n_bad++; $display("FAIL release_no_pulse: %0d pulses expected 0", pulse_cnt[0]);
    end
    BUT1 = 1'b0;
    lat = 0;
    while (SET !== 1'b1 && lat < 100) begin cycle(); lat++; end
    repeat (5) cycle();
    pulse_cnt[0] = 0;
    dropped = 1'b0;
    BUT1 = 1'b1;
    repeat (20) begin cycle(); if (SET !== 1'b1) dropped = 1'b1; end
    BUT1 = 1'b0;
    repeat (4) begin cycle(); if (SET !== 1'b1) dropped = 1'b1; end
    BUT1 = 1'b1;
    lat = 0;
    while (SET !== 1'b0 && lat < 120) begin cycle(); lat++; end
    n_cmp++;
    if (dropped || pulse_cnt[0] != 0) begin
      n_bad++; $display("FAIL release_glitch_hold: dropped=%b pulses %0d expected 0/0", dropped, pulse_cnt[0]);
    end
    n_cmp++;
    if (SET !== 1'b0 || lat < LAT_MIN || lat > LAT_MAX) begin
      n_bad++; $display("FAIL release_glitch_requalify: SET=%b latency %0d expected 0 within %0d..%0d", SET, lat, LAT_MIN, LAT_MAX);
    end
  endtask

  task automatic test_both();
    int lat;
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 20)) cycle();
      BUT1 = 1'b0; BUT2 = 1'b0;
      lat = 0;
      while (SET !== 1'b1 && RESET !== 1'b1 && lat < 100) begin cycle(); lat++; end
      n_cmp++;
      if (SET !== 1'b1 || RESET !== 1'b1) begin
        n_bad++; $display("FAIL both_rise_together: SET=%b RESET=%b expected 1/1", SET, RESET);
      end
      n_cmp++;
      if (SET_PULSE !== PULSE_EN || RESET_PULSE !== PULSE_EN) begin
        n_bad++; $display("FAIL both_pulses_together: SET_PULSE=%b RESET_PULSE=%b expected %b/%b",
                          SET_PULSE, RESET_PULSE, PULSE_EN, PULSE_EN);
      end
      repeat (5) cycle();
      BUT1 = 1'b1; BUT2 = 1'b1;
      lat = 0;
      while ((SET !== 1'b0 || RESET !== 1'b0) && lat < 100) begin cycle(); lat++; end
      n_cmp++;
      if (SET !== 1'b0 || RESET !== 1'b0) begin
        n_bad++; $display("FAIL both_release: SET=%b RESET=%b expected 0/0", SET, RESET);
      end
    end
  endtask

  task automatic test_random();
    int hold [2];
    int rises;
    logic prev_set;
    hold[0] = 1; hold[1] = 1;
    rises = 0;
    prev_set = SET;
    for (int t = 0; t < 2500; t++) begin
      for (int c = 0; c < 2; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          if (c == 0) BUT1 = ~BUT1;
          else        BUT2 = ~BUT2;
          hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 14);
        end
      end
      cycle();
      if (SET === 1'b1 && prev_set === 1'b0) rises++;
      prev_set = SET;
    end
    BUT1 = 1'b1; BUT2 = 1'b1;
    repeat (80) cycle();
    n_cmp++;
    if (SET !== 1'b0 || RESET !== 1'b0) begin
      n_bad++; $display("FAIL random_settle_released: SET=%b RESET=%b expected 0/0", SET, RESET);
    end
  endtask

  initial begin
    pulse_cnt[0] = 0; pulse_cnt[1] = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_both();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
